cu_command_arbiter: RTL and testbench

Credit-based command arbiter sitting directly downstream of the compute-unit control stage. It takes the compute unit's read and write command streams (`CommandBufferLine`) and buffers each in its own FIFO. It merges them round-robin onto the single PSL command interface, gated by PSL command credits (croom). Per-source `BufferStatus` goes back upstream as the read/write buffer status the compute unit throttles on.

---
 rtl/cu_command_arbiter_pkg.sv | 44 ++++
 rtl/cu_command_arbiter_if.sv | 28 ++
 rtl/cu_command_fifo.sv | 59 +++++
 rtl/cu_command_arbiter.sv | 149 ++++++++++++++
 tb/tb_cu_command_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_command_arbiter_pkg.sv
// Shared types and constants for the compute-unit command arbiter.
// Command/status structs are shared between the interface, the FIFOs and the top.
package cu_command_arbiter_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    LOAD     = 2'd1,
    RUN      = 2'd2,
    DRAIN    = 2'd3
  } ArbiterState;

  localparam logic ARB_GRANT_READ  = 1'b0;
  localparam logic ARB_GRANT_WRITE = 1'b1;

  localparam int DEFAULT_FIFO_DEPTH    = 16;
  localparam int DEFAULT_ALFULL_MARGIN = 4;
  localparam int DEFAULT_CREDIT_WIDTH  = 8;

  typedef struct packed {
    logic        valid;
    logic [12:0] command;
    logic [7:0]  tag;
    logic [11:0] size;
    logic [63:0] address;
  } CommandBufferLine;

  typedef struct packed {
    logic valid;
    logic empty;
    logic full;
    logic alfull;
  } BufferStatus;

  function automatic BufferStatus make_status(input logic empty, input logic full,
                                              input logic alfull);
    BufferStatus s;
    s.valid  = ~empty;
    s.empty  = empty;
    s.full   = full;
    s.alfull = alfull;
    return s;
  endfunction

endpackage

// File: rtl/cu_command_arbiter_if.sv
// Command bus between the compute-unit control stage (master) and the arbiter (slave):
// the two upstream command streams, their buffer status, and the merged PSL command.
interface cu_command_arbiter_if;
  import cu_command_arbiter_pkg::*;

  CommandBufferLine read_command_in;
  CommandBufferLine write_command_in;
  CommandBufferLine command_out;
  BufferStatus      read_buffer_status;
  BufferStatus      write_buffer_status;

  modport master (
    output read_command_in,
    output write_command_in,
    input  command_out,
    input  read_buffer_status,
    input  write_buffer_status
  );

  modport slave (
    input  read_command_in,
    input  write_command_in,
    output command_out,
    output read_buffer_status,
    output write_buffer_status
  );

endinterface

// File: rtl/cu_command_fifo.sv
// Synchronous FIFO of CommandBufferLine with occupancy count and empty/full/alfull flags.
// Pushes to a full FIFO and pops from an empty FIFO are ignored; flags derive from the count.
module cu_command_fifo
  import cu_command_arbiter_pkg::*;
#(
  parameter int DEPTH         = DEFAULT_FIFO_DEPTH,
  parameter int ALFULL_MARGIN = DEFAULT_ALFULL_MARGIN
) (
  input  logic                       clock,
  input  logic                       rstn,
  input  logic                       push,
  input  logic                       pop,
  input  CommandBufferLine           wdata,
  output CommandBufferLine           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       alfull
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  CommandBufferLine mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata  = mem[rd_ptr];
  assign empty  = (count == '0);
  assign full   = (int'(count) == DEPTH);
  assign alfull = ((DEPTH - int'(count)) <= ALFULL_MARGIN);

endmodule

// File: rtl/cu_command_arbiter.sv
// Credit-gated round-robin merge of the read and write command FIFOs onto the PSL command bus.
//   state    | meaning
//   DISABLED | no push, no issue
//   LOAD     | one cycle: credits and credit_max loaded from croom_in
//   RUN      | pushes accepted, commands issued
//   DRAIN    | pushes ignored, issue continues until both FIFOs are empty
module cu_command_arbiter
  import cu_command_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH    = DEFAULT_FIFO_DEPTH,
  parameter int ALFULL_MARGIN = DEFAULT_ALFULL_MARGIN,
  parameter int CREDIT_WIDTH  = DEFAULT_CREDIT_WIDTH
) (
  input  logic                    clock,
  input  logic                    rstn,
  input  logic                    enabled_in,
  input  logic [CREDIT_WIDTH-1:0] croom_in,
  input  logic                    credit_return_in,
  cu_command_arbiter_if.slave     cmd,
  output logic [CREDIT_WIDTH-1:0] credits_out,
  output logic [1:0]              error_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ArbiterState             state;
  logic                    last_grant;
  logic [CREDIT_WIDTH-1:0] credits;
  logic [CREDIT_WIDTH-1:0] credit_max;
  CommandBufferLine        command_q;

  CommandBufferLine rd_head, wr_head;
  logic [CW-1:0]    rd_count, wr_count;
  logic             rd_empty, rd_full, rd_alfull;
  logic             wr_empty, wr_full, wr_alfull;

  logic accepting, issuing, has_credit;
  logic rd_push, wr_push, rd_eligible, wr_eligible;
  logic grant_rd, grant_wr, issue, overflow;

  assign accepting   = (state == RUN);
  assign issuing     = (state == RUN) || (state == DRAIN);
  assign has_credit  = (credits != '0);
  assign rd_push     = accepting && cmd.read_command_in.valid;
  assign wr_push     = accepting && cmd.write_command_in.valid;
  assign rd_eligible = issuing && !rd_empty && has_credit;
  assign wr_eligible = issuing && !wr_empty && has_credit;
  assign overflow    = (rd_push && rd_full) || (wr_push && wr_full);

  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (rd_eligible && wr_eligible) begin
      if (last_grant == ARB_GRANT_WRITE) grant_rd = 1'b1;
      else                               grant_wr = 1'b1;
    end else begin
      grant_rd = rd_eligible;
      grant_wr = wr_eligible;
    end
  end

  assign issue = grant_rd || grant_wr;

  cu_command_fifo #(
    .DEPTH         (FIFO_DEPTH),
    .ALFULL_MARGIN (ALFULL_MARGIN)
  ) u_read_fifo (
    .clock  (clock),
    .rstn   (rstn),
    .push   (rd_push),
    .pop    (grant_rd),
    .wdata  (cmd.read_command_in),
    .rdata  (rd_head),
    .count  (rd_count),
    .empty  (rd_empty),
    .full   (rd_full),
    .alfull (rd_alfull)
  );

  cu_command_fifo #(
    .DEPTH         (FIFO_DEPTH),
    .ALFULL_MARGIN (ALFULL_MARGIN)
  ) u_write_fifo (
    .clock  (clock),
    .rstn   (rstn),
    .push   (wr_push),
    .pop    (grant_wr),
    .wdata  (cmd.write_command_in),
    .rdata  (wr_head),
    .count  (wr_count),
    .empty  (wr_empty),
    .full   (wr_full),
    .alfull (wr_alfull)
  );

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state       <= DISABLED;
      last_grant  <= ARB_GRANT_WRITE;
      credits     <= '0;
      credit_max  <= '0;
      credits_out <= '0;
      error_out   <= '0;
      command_q   <= '0;
    end else begin
      // credits_out trails the internal counter by one cycle
      credits_out <= credits;

      command_q <= '0;
      if (grant_rd) begin
        command_q       <= rd_head;
        command_q.valid <= 1'b1;
        last_grant      <= ARB_GRANT_READ;
      end else if (grant_wr) begin
        command_q       <= wr_head;
        command_q.valid <= 1'b1;
        last_grant      <= ARB_GRANT_WRITE;
      end

      if (state == LOAD) begin
        credits    <= croom_in;
        credit_max <= croom_in;
      end else if (issue && !credit_return_in) begin
        credits <= credits - CREDIT_WIDTH'(1);
      end else if (!issue && credit_return_in) begin
        if (credits == credit_max) error_out[1] <= 1'b1;
        else                       credits <= credits + CREDIT_WIDTH'(1);
      end

      if (overflow) error_out[0] <= 1'b1;

      case (state)
        DISABLED: if (enabled_in) state <= LOAD;
        LOAD:     state <= RUN;
        RUN:      if (!enabled_in) state <= DRAIN;
        DRAIN: begin
          if (enabled_in)                            state <= RUN;
          else if (rd_count == '0 && wr_count == '0) state <= DISABLED;
        end
        default:  state <= DISABLED;
      endcase
    end
  end

  assign cmd.command_out         = command_q;
  assign cmd.read_buffer_status  = make_status(rd_empty, rd_full, rd_alfull);
  assign cmd.write_buffer_status = make_status(wr_empty, wr_full, wr_alfull);

endmodule

// File: tb/tb_cu_command_arbiter.sv
// Scoreboard bench for cu_command_arbiter: a queue-level reference model predicts each issued
// command and the per-cycle credits/status/error, and a negedge monitor compares the DUT.
module tb_cu_command_arbiter;
  import cu_command_arbiter_pkg::CommandBufferLine;
  import cu_command_arbiter_pkg::BufferStatus;

  localparam int DEPTH  = 16;
  localparam int MARGIN = 4;

  typedef enum int {PH_OFF, PH_LOAD, PH_RUN, PH_DRAIN} phase_t;

  logic       clock = 1'b0;
  logic       rstn = 1'b0;
  logic       enabled_in = 1'b0;
  logic       credit_return_in = 1'b0;
  logic [7:0] croom_in = '0;
  logic [7:0] credits_out;
  logic [1:0] error_out;

  cu_command_arbiter_if bus ();

  cu_command_arbiter #(
    .FIFO_DEPTH    (DEPTH),
    .ALFULL_MARGIN (MARGIN),
    .CREDIT_WIDTH  (8)
  ) dut (
    .clock            (clock),
    .rstn             (rstn),
    .enabled_in       (enabled_in),
    .croom_in         (croom_in),
    .credit_return_in (credit_return_in),
    .cmd              (bus.slave),
    .credits_out      (credits_out),
    .error_out        (error_out)
  );

  always #5 clock = ~clock;

  // reference model state
  phase_t           m_phase = PH_OFF;
  CommandBufferLine rq[$];
  CommandBufferLine wq[$];
  CommandBufferLine expq[$];
  int               m_credits = 0;
  int               m_max = 0;
  int               m_credits_out = 0;
  logic [1:0]       m_err = '0;
  bit               m_last_write = 1'b1;

  int tests = 0;
  int fails = 0;
  int n_out = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic BufferStatus exp_status(input int sz);
    BufferStatus s;
    s.valid  = (sz != 0);
    s.empty  = (sz == 0);
    s.full   = (sz == DEPTH);
    s.alfull = ((DEPTH - sz) <= MARGIN);
    return s;
  endfunction

  task automatic model_clear();
    m_phase = PH_OFF;
    rq.delete();
    wq.delete();
    expq.delete();
    m_credits = 0;
    m_max = 0;
    m_credits_out = 0;
    m_err = '0;
    m_last_write = 1'b1;
  endtask

  task automatic model_step();
    int               rsz = rq.size();
    int               wsz = wq.size();
    CommandBufferLine rc = bus.read_command_in;
    CommandBufferLine wc = bus.write_command_in;
    bit               re, we, do_r, do_w, issued;
    m_credits_out = m_credits;
    do_r = 1'b0;
    do_w = 1'b0;
    if (m_phase == PH_RUN || m_phase == PH_DRAIN) begin
      re = (rsz > 0) && (m_credits > 0);
      we = (wsz > 0) && (m_credits > 0);
      if (re && we) begin
        do_r = m_last_write;
        do_w = !m_last_write;
      end else begin
        do_r = re;
        do_w = we;
      end
    end
    if (do_r) begin expq.push_back(rq.pop_front()); m_last_write = 1'b0; end
    if (do_w) begin expq.push_back(wq.pop_front()); m_last_write = 1'b1; end
    issued = do_r || do_w;
    if (m_phase == PH_LOAD) begin
      m_credits = int'(croom_in);
      m_max     = int'(croom_in);
    end else if (issued && !credit_return_in) begin
      m_credits--;
    end else if (!issued && credit_return_in) begin
      if (m_credits == m_max) m_err[1] = 1'b1;
      else                    m_credits++;
    end
    if (m_phase == PH_RUN) begin
      if (rc.valid) begin
        if (rsz == DEPTH) m_err[0] = 1'b1;
        else              rq.push_back(rc);
      end
      if (wc.valid) begin
        if (wsz == DEPTH) m_err[0] = 1'b1;
        else              wq.push_back(wc);
      end
    end
    case (m_phase)
      PH_OFF:   if (enabled_in) m_phase = PH_LOAD;
      PH_LOAD:  m_phase = PH_RUN;
      PH_RUN:   if (!enabled_in) m_phase = PH_DRAIN;
      PH_DRAIN: begin
        if (enabled_in)                  m_phase = PH_RUN;
        else if (rsz == 0 && wsz == 0)   m_phase = PH_OFF;
      end
      default:  m_phase = PH_OFF;
    endcase
  endtask

  task automatic monitor_step();
    CommandBufferLine e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("cmd_valid", 128'(bus.command_out.valid), 128'(1));
      check("cmd_data", 128'(bus.command_out), 128'(e));
    end else begin
      check("cmd_idle", 128'(bus.command_out.valid), 128'(0));
    end
    if (bus.command_out.valid) n_out++;
    check("credits_out", 128'(credits_out), 128'(m_credits_out));
    check("error_out", 128'(error_out), 128'(m_err));
    check("rd_status", 128'(bus.read_buffer_status), 128'(exp_status(rq.size())));
    check("wr_status", 128'(bus.write_buffer_status), 128'(exp_status(wq.size())));
  endtask

  always @(posedge clock) if (rstn) model_step();
  always @(negedge clock) if (rstn) monitor_step();

  function automatic CommandBufferLine rand_cmd();
    CommandBufferLine c;
    c.valid   = 1'b1;
    c.command = 13'($urandom);
    c.tag     = 8'($urandom);
    c.size    = 12'($urandom);
    c.address = {$urandom, $urandom};
    return c;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive(input bit r, input bit w, input bit ret);
    bus.read_command_in  = r ? rand_cmd() : '0;
    bus.write_command_in = w ? rand_cmd() : '0;
    credit_return_in     = ret;
    step(1);
    bus.read_command_in  = '0;
    bus.write_command_in = '0;
    credit_return_in     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0);
  endtask

  // Asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2;
    model_clear();
    enabled_in = 1'b0;
    croom_in   = '0;
    rstn       = 1'b0;
    #1;
    check("rst_cmd", 128'(bus.command_out), 128'(0));
    check("rst_credits", 128'(credits_out), 128'(0));
    check("rst_error", 128'(error_out), 128'(0));
    check("rst_rd_status", 128'(bus.read_buffer_status), 128'(4'b0100));
    check("rst_wr_status", 128'(bus.write_buffer_status), 128'(4'b0100));
    step(1);
    rstn = 1'b1;
  endtask

  task automatic enable(input int croom);
    croom_in   = 8'(croom);
    enabled_in = 1'b1;
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int cnt;
    bus.read_command_in  = '0;
    bus.write_command_in = '0;
    step(2);

    // single command: latency 2 cycles, credits_out one cycle later
    do_reset();
    enable(4);
    idle(1);
    check("t1_credits_loaded", 128'(credits_out), 128'(4));
    drive(1, 0, 0);
    idle(1);
    check("t1_issue_valid", 128'(bus.command_out.valid), 128'(1));
    check("t1_credits_lag", 128'(credits_out), 128'(4));
    idle(1);
    check("t1_credits_after", 128'(credits_out), 128'(3));

    // both sources every cycle: alternate R,W
    do_reset();
    enable(64);
    base = n_out;
    repeat (6) drive(1, 1, 0);
    idle(10);
    check("t2_issued", 128'(n_out - base), 128'(12));

    // credit starvation, one return, then reset mid-DRAIN
    do_reset();
    enable(2);
    base = n_out;
    repeat (5) drive(1, 0, 0);
    idle(4);
    check("t3_issued", 128'(n_out - base), 128'(2));
    check("t3_credits", 128'(credits_out), 128'(0));
    check("t3_rd_nonempty", 128'(bus.read_buffer_status.empty), 128'(0));
    drive(0, 0, 1);
    idle(4);
    check("t3_after_return", 128'(n_out - base), 128'(3));
    enabled_in = 1'b0;
    repeat (2) drive(1, 1, 0);
    idle(2);
    do_reset();

    // overflow of a credit-less FIFO
    enable(0);
    repeat (17) drive(1, 0, 0);
    check("t4_full", 128'(bus.read_buffer_status.full), 128'(1));
    check("t4_alfull", 128'(bus.read_buffer_status.alfull), 128'(1));
    check("t4_overflow", 128'(error_out), 128'(2'b01));

    // simultaneous issue and return, then return at credit_max
    do_reset();
    enable(1);
    drive(1, 0, 0);
    drive(0, 0, 1);
    idle(2);
    check("t5_credits_same", 128'(credits_out), 128'(1));
    drive(0, 0, 1);
    idle(1);
    check("t5_clamp_err", 128'(error_out), 128'(2'b10));
    check("t5_clamp_credits", 128'(credits_out), 128'(1));

    // drain with queued entries; pushes ignored once draining
    do_reset();
    enable(8);
    base = n_out;
    repeat (3) drive(1, 1, 0);
    enabled_in = 1'b0;
    repeat (3) drive(1, 1, 0);
    cnt = 0;
    while ((!bus.read_buffer_status.empty || !bus.write_buffer_status.empty) && cnt < 50) begin
      idle(1);
      cnt++;
    end
    check("t6_drain_bound", 128'(cnt < 50), 128'(1));
    idle(3);
    check("t6_issued", 128'(n_out - base), 128'(8));

    // randomized traffic
    do_reset();
    enable($urandom_range(1, 12));
    for (int i = 0; i < 800; i++) begin
      bit r, w, ret;
      r   = ($urandom_range(0, 99) < 40);
      w   = ($urandom_range(0, 99) < 40);
      ret = ((m_max - m_credits) > 0 && $urandom_range(0, 99) < 35) ||
            ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 3) enabled_in = ~enabled_in;
      if ($urandom_range(0, 99) < 5) croom_in = 8'($urandom_range(1, 12));
      drive(r, w, ret);
    end
    enabled_in = 1'b1;
    idle(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
